// File: rtl/led_pkg.sv
// Shared encodings for the LED heartbeat driver: drive modes and heartbeat envelope states.
package led_pkg;

  typedef enum logic [1:0] {
    MODE_STEADY    = 2'd0,
    MODE_BREATHE   = 2'd1,
    MODE_HEARTBEAT = 2'd2,
    MODE_CHASE     = 2'd3
  } led_mode_t;

  typedef enum logic [2:0] {
    HB_UP1  = 3'd0,
    HB_DN1  = 3'd1,
    HB_UP2  = 3'd2,
    HB_DN2  = 3'd3,
    HB_REST = 3'd4
  } hb_state_t;

endpackage

// File: rtl/led_pwm_bank.sv
// Per-channel PWM comparators; each output is registered as (pwm_cnt < duty).
module led_pwm_bank #(
  parameter int N_CH  = 8,
  parameter int PWM_W = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [PWM_W-1:0]            pwm_cnt,
  input  logic [N_CH-1:0][PWM_W-1:0]  duties,
  output logic [N_CH-1:0]             led_out
);

  logic [N_CH-1:0] cmp;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assign cmp[i] = (pwm_cnt < duties[i]);
  end

  always_ff @(posedge clk) begin
    if (rst) led_out <= '0;
    else     led_out <= cmp;
  end

endmodule

// File: rtl/led_heartbeat_driver.sv
// LED envelope generator (steady / breathe / heartbeat / chase) feeding a shared PWM comparator bank.
module led_heartbeat_driver
  import led_pkg::*;
#(
  parameter int N_CH        = 8,
  parameter int PWM_W       = 8,
  parameter int PRESCALE    = 4688,
  parameter int REST_TICKS  = 256,
  parameter int CHASE_TICKS = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic [PWM_W-1:0]  brightness,
  output logic [N_CH-1:0]   led_out,
  output logic              cycle_done
);

  localparam int CW = $clog2(PRESCALE);
  localparam int RW = (REST_TICKS  > 1) ? $clog2(REST_TICKS)  : 1;
  localparam int KW = (CHASE_TICKS > 1) ? $clog2(CHASE_TICKS) : 1;
  localparam int IW = (N_CH        > 1) ? $clog2(N_CH)        : 1;

  localparam logic [PWM_W-1:0] MAXV      = {PWM_W{1'b1}};
  localparam logic [PWM_W-1:0] HALF      = MAXV >> 1;
  localparam logic [CW-1:0]    PS_LAST   = CW'(PRESCALE - 1);
  localparam logic [RW-1:0]    REST_LAST = RW'(REST_TICKS - 1);
  localparam logic [KW-1:0]    CH_LAST   = KW'(CHASE_TICKS - 1);
  localparam logic [IW-1:0]    IDX_LAST  = IW'(N_CH - 1);

  logic [PWM_W-1:0] pwm_cnt, bright_lat, level, level_d, lvl_up, lvl_dn;
  logic [CW-1:0]    presc, presc_d;
  logic [RW-1:0]    rest_cnt, rest_d;
  logic [KW-1:0]    chase_cnt, chase_d;
  logic [IW-1:0]    idx, idx_d;
  logic             dir, dir_d;       // breathe direction, 1 = descending
  logic             tick, restart, cd_d;
  hb_state_t        hb, hb_d;
  led_mode_t        act_mode, mode_d;
  logic [N_CH-1:0][PWM_W-1:0] duty;

  assign tick    = (presc == PS_LAST);
  assign restart = (mode != act_mode) || !en;
  assign lvl_up  = (level == MAXV) ? level : level + 1'b1;
  assign lvl_dn  = (level == '0)   ? level : level - 1'b1;

  always_comb begin
    presc_d = presc;
    level_d = level;
    dir_d   = dir;
    hb_d    = hb;
    rest_d  = rest_cnt;
    chase_d = chase_cnt;
    idx_d   = idx;
    mode_d  = led_mode_t'(mode);
    cd_d    = 1'b0;
    if (restart) begin
      presc_d = '0;
      level_d = '0;
      dir_d   = 1'b0;
      hb_d    = HB_UP1;
      rest_d  = '0;
      chase_d = '0;
      idx_d   = '0;
    end else begin
      presc_d = tick ? '0 : presc + 1'b1;
      if (act_mode == MODE_STEADY) begin
        cd_d = (pwm_cnt == MAXV);
      end else if (tick) begin
        case (act_mode)
          MODE_BREATHE: begin
            if (!dir) begin
              level_d = lvl_up;
              if (lvl_up == MAXV) dir_d = 1'b1;
            end else begin
              level_d = lvl_dn;
              if (lvl_dn == '0) begin
                dir_d = 1'b0;
                cd_d  = 1'b1;
              end
            end
          end
          MODE_HEARTBEAT: begin
            case (hb)
              HB_UP1: begin
                level_d = lvl_up;
                if (lvl_up == MAXV) hb_d = HB_DN1;
              end
              HB_DN1: begin
                level_d = lvl_dn;
                if (lvl_dn == '0) hb_d = HB_UP2;
              end
              HB_UP2: begin
                // clamp to the half-height peak so tiny PWM widths cannot overshoot
                level_d = (lvl_up > HALF) ? HALF : lvl_up;
                if (lvl_up >= HALF) hb_d = HB_DN2;
              end
              HB_DN2: begin
                level_d = lvl_dn;
                if (lvl_dn == '0) begin
                  hb_d   = HB_REST;
                  rest_d = '0;
                end
              end
              HB_REST: begin
                level_d = '0;
                if (rest_cnt == REST_LAST) begin
                  hb_d   = HB_UP1;
                  rest_d = '0;
                  cd_d   = 1'b1;
                end else begin
                  rest_d = rest_cnt + 1'b1;
                end
              end
              default: hb_d = HB_UP1;
            endcase
          end
          MODE_CHASE: begin
            if (chase_cnt == CH_LAST) begin
              chase_d = '0;
              if (idx == IDX_LAST) begin
                idx_d = '0;
                cd_d  = 1'b1;
              end else begin
                idx_d = idx + 1'b1;
              end
            end else begin
              chase_d = chase_cnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Duties follow the envelope live; only brightness is sampled at the PWM wrap.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      duty[i] = '0;
      if (en) begin
        case (act_mode)
          MODE_STEADY:    duty[i] = bright_lat;
          MODE_BREATHE:   duty[i] = level;
          MODE_HEARTBEAT: duty[i] = level;
          MODE_CHASE:     if (idx == IW'(i)) duty[i] = bright_lat;
          default:        duty[i] = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt    <= '0;
      bright_lat <= '0;
      presc      <= '0;
      level      <= '0;
      dir        <= 1'b0;
      hb         <= HB_UP1;
      rest_cnt   <= '0;
      chase_cnt  <= '0;
      idx        <= '0;
      act_mode   <= MODE_STEADY;
      cycle_done <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      if (pwm_cnt == MAXV) bright_lat <= brightness;
      presc      <= presc_d;
      level      <= level_d;
      dir        <= dir_d;
      hb         <= hb_d;
      rest_cnt   <= rest_d;
      chase_cnt  <= chase_d;
      idx        <= idx_d;
      act_mode   <= mode_d;
      cycle_done <= cd_d;
    end
  end

  led_pwm_bank #(.N_CH(N_CH), .PWM_W(PWM_W)) u_bank (
    .clk     (clk),
    .rst     (rst),
    .pwm_cnt (pwm_cnt),
    .duties  (duty),
    .led_out (led_out)
  );

endmodule

// File: tb/tb_led_heartbeat_driver.sv
// Scoreboard bench: a phase-arithmetic model predicts led_out/cycle_done each clock; a negedge monitor compares.
module tb_led_heartbeat_driver;

  localparam int N_CH = 4, PWM_W = 4, PRESCALE = 2, REST_TICKS = 3, CHASE_TICKS = 2;
  localparam int MAXV = (1 << PWM_W) - 1;
  localparam int HALF = MAXV / 2;

  typedef struct packed {
    logic [N_CH-1:0] led;
    logic            cd;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic [1:0]       mode = 2'd0;
  logic [PWM_W-1:0] brightness = '0;
  logic [N_CH-1:0]  led_out;
  logic             cycle_done;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  // model state: pwm position, clocks since envelope restart, active mode, latched brightness
  int m_pwm = 0, m_c = 0, m_mode = 0, m_blat = 0;

  always #5 clk = ~clk;

  led_heartbeat_driver #(
    .N_CH(N_CH), .PWM_W(PWM_W), .PRESCALE(PRESCALE),
    .REST_TICKS(REST_TICKS), .CHASE_TICKS(CHASE_TICKS)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .brightness(brightness),
    .led_out(led_out), .cycle_done(cycle_done)
  );

  function automatic int period_of(int md);
    case (md)
      1:       return 2 * MAXV;
      2:       return 2 * MAXV + 2 * HALF + REST_TICKS;
      3:       return CHASE_TICKS * N_CH;
      default: return 1;
    endcase
  endfunction

  function automatic int level_of(int md, int t);
    int p;
    p = t % period_of(md);
    if (md == 1) return (p <= MAXV) ? p : 2 * MAXV - p;
    if (md == 2) begin
      if (p <= MAXV)                return p;
      if (p <= 2 * MAXV)            return 2 * MAXV - p;
      if (p <= 2 * MAXV + HALF)     return p - 2 * MAXV;
      if (p <= 2 * MAXV + 2 * HALF) return 2 * MAXV + 2 * HALF - p;
    end
    return 0;
  endfunction

  function automatic int duty_of(int ch, int md, int t, int blat);
    case (md)
      0:       return blat;
      3:       return (((t / CHASE_TICKS) % N_CH) == ch) ? blat : 0;
      default: return level_of(md, t);
    endcase
  endfunction

  always @(posedge clk) begin
    exp_t e;
    int   t;
    e = '0;
    if (rst) begin
      m_pwm = 0; m_c = 0; m_mode = 0; m_blat = 0;
    end else begin
      t = m_c / PRESCALE;
      for (int i = 0; i < N_CH; i++)
        e.led[i] = en && (m_pwm < duty_of(i, m_mode, t, m_blat));
      if (en && (int'(mode) == m_mode)) begin
        if (m_mode == 0)
          e.cd = (m_pwm == MAXV);
        else if ((m_c % PRESCALE) == PRESCALE - 1)
          e.cd = (((m_c + 1) / PRESCALE) % period_of(m_mode)) == 0;
      end
      if (int'(mode) != m_mode) begin
        m_mode = int'(mode);
        m_c    = 0;
      end else if (!en) begin
        m_c = 0;
      end else begin
        m_c++;
      end
      if (m_pwm == MAXV) m_blat = int'(brightness);
      m_pwm = (m_pwm + 1) % (MAXV + 1);
    end
    exp_q.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_tests++;
      if (led_out !== e.led || cycle_done !== e.cd) begin
        n_fail++;
        $display("FAIL out@cyc%0d: got led_out=%b cycle_done=%b, want led_out=%b cycle_done=%b",
                 cyc, led_out, cycle_done, e.led, e.cd);
      end
    end
  end

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    run(3);
    rst = 1'b0; en = 1'b1; mode = 2'd0; brightness = 4'd5;
    run(40);
    mode = 2'd1;
    for (int i = 0; i < 13; i++) begin
      brightness = 4'($urandom_range(0, MAXV));
      run(10);
    end
    mode = 2'd2;
    run(200);
    mode = 2'd3; brightness = 4'd15;
    run(40);
    mode = 2'd2;
    run(45);
    mode = 2'd1;
    run(20);
    en = 1'b0;
    run(10);
    en = 1'b1;
    run(40);
    mode = 2'd2;
    run(66);
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    run(40);
    for (int i = 0; i < 600; i++) begin
      int r;
      r   = int'($urandom_range(0, 99));
      rst = (r == 0);
      if (r >= 1 && r <= 2) en = ~en;
      if (r >= 3 && r <= 4) mode = 2'($urandom_range(0, 3));
      if (r >= 5 && r <= 14) brightness = 4'($urandom_range(0, MAXV));
      run(1);
    end
    rst = 1'b0; en = 1'b1;
    run(3);
    n_tests++;
    if (exp_q.size() > 1) begin
      n_fail++;
      $display("FAIL drain: got %0d pending, want at most 1", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
